// File: rtl/ber_pkg.sv
// Shared constants, state type and saturating arithmetic helper for the
// parallel burst sender.
package ber_pkg;

  localparam int BURST_LEN = 1024;
  localparam logic [63:0] ALIGN_WORD = 64'h0123_4567_89AB_CDEF;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    MARK,
    DATA
  } state_t;

  // Adds a 0..64 bit-error count to a 64-bit total, sticking at all-ones on overflow.
  function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [6:0] b);
    logic [64:0] sum;
    sum = {1'b0, a} + {58'd0, b};
    return sum[64] ? '1 : sum[63:0];
  endfunction

endpackage

// File: rtl/popcnt64.sv
// Combinational population count of a 64-bit word.
module popcnt64 (
  input  logic [63:0] din,
  output logic [6:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 64; i++) begin
      count = count + {6'd0, din[i]};
    end
  end

endmodule

// File: rtl/parallel_send.sv
// Sends optional alignment words, a one-cycle INIT marker, then a fixed-length
// burst of counter words with optional single-word error injection.
module parallel_send
  import ber_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        CLR,
  input  logic        START,
  input  logic [7:0]  ALIGN_LEN,
  input  logic        DORDY,
  input  logic        ERR_INJ,
  input  logic [63:0] ERR_MASK,
  output logic        DOPUSH,
  output logic [63:0] DOUT,
  output logic        INIT,
  output logic        BUSY,
  output logic [57:0] SENT_CNT,
  output logic [63:0] INJ_CNT
);

  state_t      state;
  logic [7:0]  align_len_q;
  logic [7:0]  align_cnt;
  logic [9:0]  burst_cnt;
  logic        burst_last;
  logic [63:0] data_cnt;
  logic [63:0] inj_cnt_q;
  logic        armed;
  logic [6:0]  mask_ones;
  logic        data_push;

  popcnt64 u_popcnt (
    .din   (ERR_MASK),
    .count (mask_ones)
  );

  assign burst_last = (burst_cnt == 10'(BURST_LEN - 1));
  assign data_push  = (state == DATA) && DORDY;
  assign BUSY       = (state != IDLE);
  assign INJ_CNT    = inj_cnt_q;

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state       <= IDLE;
      align_len_q <= '0;
      align_cnt   <= '0;
      burst_cnt   <= '0;
      data_cnt    <= '0;
      inj_cnt_q   <= '0;
      armed       <= 1'b0;
      DOPUSH      <= 1'b0;
      DOUT        <= '0;
      INIT        <= 1'b0;
      SENT_CNT    <= '0;
    end else if (CLR) begin
      state     <= IDLE;
      align_cnt <= '0;
      burst_cnt <= '0;
      data_cnt  <= '0;
      inj_cnt_q <= '0;
      armed     <= 1'b0;
      DOPUSH    <= 1'b0;
      DOUT      <= '0;
      INIT      <= 1'b0;
      SENT_CNT  <= '0;
    end else begin
      DOPUSH <= 1'b0;
      INIT   <= 1'b0;
      // A push that consumes the armed flag re-arms only from a fresh ERR_INJ.
      armed     <= (data_push && armed) ? ERR_INJ : (armed | ERR_INJ);
      inj_cnt_q <= (data_push && armed) ? sat_add64(inj_cnt_q, mask_ones) : inj_cnt_q;

      case (state)
        IDLE: begin
          if (START) begin
            align_len_q <= ALIGN_LEN;
            align_cnt   <= '0;
            state       <= (ALIGN_LEN != 8'd0) ? ALIGN : MARK;
          end
        end
        ALIGN: begin
          if (DORDY) begin
            DOPUSH <= 1'b1;
            DOUT   <= ALIGN_WORD;
            if (align_cnt == align_len_q - 8'd1) begin
              align_cnt <= '0;
              state     <= MARK;
            end else begin
              align_cnt <= align_cnt + 8'd1;
            end
          end
        end
        MARK: begin
          INIT  <= 1'b1;
          state <= DATA;
        end
        DATA: begin
          if (DORDY) begin
            DOPUSH    <= 1'b1;
            DOUT      <= armed ? (data_cnt ^ ERR_MASK) : data_cnt;
            data_cnt  <= data_cnt + 64'd1;
            SENT_CNT  <= SENT_CNT + 58'd1;
            burst_cnt <= burst_cnt + 10'd1;
            if (burst_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_send.sv
// Randomised bench for parallel_send checked cycle-by-cycle against a
// count-based behavioural model of the burst protocol.
module tb_parallel_send;
  import ber_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTX = 1'b0;
  logic        CLR = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  ALIGN_LEN = '0;
  logic        DORDY = 1'b0;
  logic        ERR_INJ = 1'b0;
  logic [63:0] ERR_MASK = '0;
  logic        DOPUSH;
  logic [63:0] DOUT;
  logic        INIT;
  logic        BUSY;
  logic [57:0] SENT_CNT;
  logic [63:0] INJ_CNT;

  parallel_send dut (
    .CLK      (CLK),
    .RSTX     (RSTX),
    .CLR      (CLR),
    .START    (START),
    .ALIGN_LEN(ALIGN_LEN),
    .DORDY    (DORDY),
    .ERR_INJ  (ERR_INJ),
    .ERR_MASK (ERR_MASK),
    .DOPUSH   (DOPUSH),
    .DOUT     (DOUT),
    .INIT     (INIT),
    .BUSY     (BUSY),
    .SENT_CNT (SENT_CNT),
    .INJ_CNT  (INJ_CNT)
  );

  always #5 CLK = ~CLK;

  int assert_count = 0;
  int fail_count = 0;

  // Model: a burst is just "words still owed" in each phase.
  int          align_left;
  int          data_left;
  bit          mark_pending;
  bit          armed_m;
  logic [63:0] ctr_m;
  logic [63:0] inj_m;
  logic [57:0] sent_m;
  logic [63:0] exp_dout;
  bit          exp_push;
  bit          exp_init;

  function automatic bit model_busy();
    return (align_left > 0) || mark_pending || (data_left > 0);
  endfunction

  task automatic reset_model();
    align_left   = 0;
    data_left    = 0;
    mark_pending = 1'b0;
    armed_m      = 1'b0;
    ctr_m        = '0;
    inj_m        = '0;
    sent_m       = '0;
    exp_dout     = '0;
    exp_push     = 1'b0;
    exp_init     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    bit          consume;
    logic [63:0] ones;
    consume  = 1'b0;
    exp_push = 1'b0;
    exp_init = 1'b0;
    if (!RSTX || CLR) begin
      reset_model();
      return;
    end
    if (!model_busy()) begin
      if (START) begin
        align_left   = int'(ALIGN_LEN);
        mark_pending = 1'b1;
        data_left    = BURST_LEN;
      end
    end else if (align_left > 0) begin
      if (DORDY) begin
        exp_push = 1'b1;
        exp_dout = ALIGN_WORD;
        align_left--;
      end
    end else if (mark_pending) begin
      mark_pending = 1'b0;
      exp_init     = 1'b1;
    end else if (DORDY) begin
      exp_push = 1'b1;
      exp_dout = ctr_m;
      if (armed_m) begin
        consume  = 1'b1;
        exp_dout = ctr_m ^ ERR_MASK;
        ones     = 64'($countones(ERR_MASK));
        inj_m    = (inj_m > (~64'd0 - ones)) ? ~64'd0 : inj_m + ones;
      end
      ctr_m  = ctr_m + 64'd1;
      sent_m = sent_m + 58'd1;
      data_left--;
    end
    armed_m = consume ? ERR_INJ : (armed_m | ERR_INJ);
  endtask

  task automatic compare_outputs();
    checkOutput("dopush", DOPUSH, exp_push);
    checkOutput("dout", DOUT, exp_dout);
    checkOutput("init", INIT, exp_init);
    checkOutput("busy", BUSY, model_busy());
    checkOutput("sent_cnt", SENT_CNT, sent_m);
    checkOutput("inj_cnt", INJ_CNT, inj_m);
  endtask

  // Drives one cycle of inputs, then updates the model and checks just after the edge.
  task automatic applyStimulus(input bit clr, input bit start, input logic [7:0] align,
                               input bit dordy, input bit err_inj);
    CLR       = clr;
    START     = start;
    ALIGN_LEN = align;
    DORDY     = dordy;
    ERR_INJ   = err_inj;
    @(posedge CLK);
    model_step();
    #1;
    compare_outputs();
  endtask

  // mode 0: DORDY always high; 1: toggles 1,0; 2: random ~75% high.
  task automatic run_to_idle(input int mode, input int max_cycles);
    bit d;
    for (int i = 0; i < max_cycles && model_busy(); i++) begin
      case (mode)
        0:       d = 1'b1;
        1:       d = (i % 2 == 0);
        default: d = ($urandom_range(0, 3) != 0);
      endcase
      applyStimulus(0, 0, 8'd0, d, 0);
    end
    checkOutput("burst_done", BUSY, 64'd0);
  endtask

  initial begin
    reset_model();
    #12;
    compare_outputs();
    RSTX = 1'b1;

    // Three alignment words, marker, then words 0..1023.
    applyStimulus(0, 1, 8'd3, 1, 0);
    run_to_idle(0, 1100);
    checkOutput("sent_b1", SENT_CNT, 64'd1024);
    checkOutput("last_b1", DOUT, 64'd1023);

    // No alignment; counter continues from 1024.
    applyStimulus(0, 1, 8'd0, 1, 0);
    run_to_idle(0, 1100);
    checkOutput("sent_b2", SENT_CNT, 64'd2048);
    checkOutput("last_b2", DOUT, 64'd2047);

    applyStimulus(0, 1, 8'd2, 1, 0);
    run_to_idle(1, 2200);
    checkOutput("sent_b3", SENT_CNT, 64'd3072);

    applyStimulus(1, 0, 8'd0, 0, 0);
    checkOutput("clr_sent", SENT_CNT, 64'd0);

    // Arm during the push of word 4 so word 5 carries the 0xFF mask.
    ERR_MASK = 64'hFF;
    applyStimulus(0, 1, 8'd0, 1, 0);
    for (int i = 0; i < 1100 && model_busy(); i++) begin
      applyStimulus(0, 0, 8'd0, 1, (ctr_m == 64'd4 && !mark_pending));
      if (exp_push && ctr_m == 64'd6) checkOutput("inj_word5", DOUT, 64'hFA);
      if (exp_push && ctr_m == 64'd7) checkOutput("clean_word6", DOUT, 64'd6);
    end
    checkOutput("inj_cnt_8", INJ_CNT, 64'd8);

    // Push the error total near the top, then inject a full-ones mask.
    ERR_MASK = '1;
    force dut.inj_cnt_q = 64'hFFFF_FFFF_FFFF_FFF0;
    inj_m = 64'hFFFF_FFFF_FFFF_FFF0;
    applyStimulus(0, 0, 8'd0, 0, 0);
    release dut.inj_cnt_q;
    applyStimulus(0, 0, 8'd0, 0, 0);
    applyStimulus(0, 1, 8'd0, 1, 1);
    run_to_idle(0, 1100);
    checkOutput("inj_sat", INJ_CNT, ~64'd0);

    // CLR together with START at word 100 aborts and wins.
    applyStimulus(1, 0, 8'd0, 0, 0);
    applyStimulus(0, 1, 8'd2, 1, 0);
    for (int i = 0; i < 200 && ctr_m != 64'd100; i++) applyStimulus(0, 0, 8'd0, 1, 0);
    applyStimulus(1, 1, 8'd0, 1, 0);
    checkOutput("clr_busy", BUSY, 64'd0);
    checkOutput("clr_dopush", DOPUSH, 64'd0);
    checkOutput("clr_dout", DOUT, 64'd0);
    applyStimulus(0, 0, 8'd0, 1, 0);
    checkOutput("clr_idle_push", DOPUSH, 64'd0);
    applyStimulus(0, 1, 8'd0, 1, 0);
    applyStimulus(0, 0, 8'd0, 1, 0);
    applyStimulus(0, 0, 8'd0, 1, 0);
    checkOutput("restart_word0", DOUT, 64'd0);
    run_to_idle(0, 1100);

    // Random bursts with stalls, stray STARTs, masks and injections.
    for (int b = 0; b < 4; b++) begin
      ERR_MASK = {$urandom, $urandom};
      applyStimulus(0, 1, 8'($urandom_range(0, 5)), 1, 0);
      for (int i = 0; i < 6000 && model_busy(); i++) begin
        ERR_MASK = {$urandom, $urandom};
        applyStimulus(0, ($urandom_range(0, 99) == 0), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      end
      checkOutput("rand_idle", BUSY, 64'd0);
    end

    // Asynchronous reset in the middle of a long alignment phase.
    applyStimulus(0, 1, 8'd200, 1, 0);
    repeat (5) applyStimulus(0, 0, 8'd0, 1, 0);
    #2;
    RSTX = 1'b0;
    #1;
    reset_model();
    compare_outputs();
    repeat (2) applyStimulus(0, 0, 8'd0, 1, 0);
    RSTX = 1'b1;
    repeat (5) applyStimulus(0, 0, 8'd0, 1, 0);
    applyStimulus(0, 1, 8'd1, 1, 0);
    run_to_idle(2, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
